// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: memory port arbiter state, owner and bus constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } arb_owner_t;

    // Wide enough for any data width up to 512 bits; users slice to their byte-enable width.
    localparam logic [63:0] MEM_BE_ALL = '1;

endpackage

// File: rtl/memory_port_arbiter.sv
// Shares the unified memory port between instruction fetch and data access.
// Data wins arbitration unless fetch has waited MAX_IF_WAIT data grants.
module memory_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_IF_WAIT = 4
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_IF_Req,
    input  logic [ADDR_WIDTH-1:0]   i_IF_Addr,
    input  logic                    i_IF_Flush,
    output logic                    o_IF_Valid,
    output logic [DATA_WIDTH-1:0]   o_IF_Data,
    input  logic                    i_DM_Req,
    input  logic                    i_DM_Write,
    input  logic [ADDR_WIDTH-1:0]   i_DM_Addr,
    input  logic [DATA_WIDTH-1:0]   i_DM_WriteData,
    input  logic [DATA_WIDTH/8-1:0] i_DM_ByteEnable,
    output logic                    o_DM_Valid,
    output logic [DATA_WIDTH-1:0]   o_DM_ReadData,
    output logic                    o_Mem_Req,
    output logic                    o_Mem_Write,
    output logic [ADDR_WIDTH-1:0]   o_Mem_Addr,
    output logic [DATA_WIDTH-1:0]   o_Mem_WriteData,
    output logic [DATA_WIDTH/8-1:0] o_Mem_ByteEnable,
    input  logic                    i_Mem_Ack,
    input  logic [DATA_WIDTH-1:0]   i_Mem_ReadData,
    output logic                    o_Busy
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = $clog2(MAX_IF_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IF_WAIT);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  drop_q, drop_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic                  if_valid_q, if_valid_d;
    logic                  dm_valid_q, dm_valid_d;

    logic       if_elig, dm_elig, grant;
    arb_owner_t grant_owner;

    // Eligibility and fixed-priority grant with the fetch starvation override.
    always_comb begin
        // A requester still holding its request during its Valid cycle must not be re-granted.
        if_elig     = i_IF_Req && !i_IF_Flush && !if_valid_q;
        dm_elig     = i_DM_Req && !dm_valid_q;
        grant       = 1'b0;
        grant_owner = OWNER_DM;
        if (state_q == IDLE) begin
            if (if_elig && (!dm_elig || cnt_q == CNT_MAX)) begin
                grant       = 1'b1;
                grant_owner = OWNER_IF;
            end else if (dm_elig) begin
                grant       = 1'b1;
                grant_owner = OWNER_DM;
            end
        end
    end

    // Next-state: bus request latching, ack handling, flush drop flag and starvation count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        resp_d      = resp_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;

        if (!i_IF_Req) begin
            cnt_d = '0;
        end else if (grant && grant_owner == OWNER_IF) begin
            cnt_d = '0;
        end else if (grant && if_elig && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant) begin
                    mem_req_d = 1'b1;
                    if (grant_owner == OWNER_IF) begin
                        mem_write_d = 1'b0;
                        mem_addr_d  = i_IF_Addr;
                        mem_wdata_d = '0;
                        mem_be_d    = MEM_BE_ALL[BE_WIDTH-1:0];
                        state_d     = IF_BUSY;
                    end else begin
                        mem_write_d = i_DM_Write;
                        mem_addr_d  = i_DM_Addr;
                        mem_wdata_d = i_DM_WriteData;
                        mem_be_d    = i_DM_ByteEnable;
                        state_d     = DM_BUSY;
                    end
                end
            end
            IF_BUSY: begin
                if (i_IF_Flush) begin
                    drop_d = 1'b1;
                end
                if (i_Mem_Ack) begin
                    mem_req_d  = 1'b0;
                    resp_d     = i_Mem_ReadData;
                    // Flush in the ack cycle itself also suppresses the response.
                    if_valid_d = !(drop_q || i_IF_Flush);
                    drop_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            DM_BUSY: begin
                if (i_Mem_Ack) begin
                    mem_req_d  = 1'b0;
                    resp_d     = i_Mem_ReadData;
                    dm_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset may land mid-transaction.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            resp_q      <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            resp_q      <= resp_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign o_Mem_Req        = mem_req_q;
    assign o_Mem_Write      = mem_write_q;
    assign o_Mem_Addr       = mem_addr_q;
    assign o_Mem_WriteData  = mem_wdata_q;
    assign o_Mem_ByteEnable = mem_be_q;
    assign o_IF_Valid       = if_valid_q;
    assign o_IF_Data        = resp_q;
    assign o_DM_Valid       = dm_valid_q;
    assign o_DM_ReadData    = resp_q;
    assign o_Busy           = (state_q != IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a cycle vector table plus corner-case sequences.
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_IF_Req = 1'b0;
    logic [31:0] i_IF_Addr = '0;
    logic        i_IF_Flush = 1'b0;
    logic        o_IF_Valid;
    logic [31:0] o_IF_Data;
    logic        i_DM_Req = 1'b0;
    logic        i_DM_Write = 1'b0;
    logic [31:0] i_DM_Addr = '0;
    logic [31:0] i_DM_WriteData = '0;
    logic [3:0]  i_DM_ByteEnable = '0;
    logic        o_DM_Valid;
    logic [31:0] o_DM_ReadData;
    logic        o_Mem_Req;
    logic        o_Mem_Write;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_WriteData;
    logic [3:0]  o_Mem_ByteEnable;
    logic        i_Mem_Ack = 1'b0;
    logic [31:0] i_Mem_ReadData = '0;
    logic        o_Busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic auto_ack = 1'b0;
    logic starve_mode = 1'b0;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_IF_WAIT(4)
    ) dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_IF_Req        (i_IF_Req),
        .i_IF_Addr       (i_IF_Addr),
        .i_IF_Flush      (i_IF_Flush),
        .o_IF_Valid      (o_IF_Valid),
        .o_IF_Data       (o_IF_Data),
        .i_DM_Req        (i_DM_Req),
        .i_DM_Write      (i_DM_Write),
        .i_DM_Addr       (i_DM_Addr),
        .i_DM_WriteData  (i_DM_WriteData),
        .i_DM_ByteEnable (i_DM_ByteEnable),
        .o_DM_Valid      (o_DM_Valid),
        .o_DM_ReadData   (o_DM_ReadData),
        .o_Mem_Req       (o_Mem_Req),
        .o_Mem_Write     (o_Mem_Write),
        .o_Mem_Addr      (o_Mem_Addr),
        .o_Mem_WriteData (o_Mem_WriteData),
        .o_Mem_ByteEnable(o_Mem_ByteEnable),
        .i_Mem_Ack       (i_Mem_Ack),
        .i_Mem_ReadData  (i_Mem_ReadData),
        .o_Busy          (o_Busy)
    );

    // Inputs applied in a cycle; expected registered outputs in the following cycle.
    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        dm_req;
        logic        dm_write;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_ifv;
        logic        e_dmv;
        logic [31:0] e_resp;
        logic        e_busy;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            i_Mem_Ack      = o_Mem_Req;
            i_Mem_ReadData = 32'h0000_0013;
        end
        // Keeps fetch ineligible in the data Valid cycle so only the starvation guard can grant it.
        if (starve_mode) i_IF_Flush = o_DM_Valid;
    endtask

    int   dm_grants;
    int   cnt_at_if;
    logic if_seen;
    logic prev_req;
    logic got_v;
    logic ifv_seen;

    initial begin
        // Single fetch 0x100, ack after 2 cycles, held through Valid cycle, then late ack in IDLE.
        vec[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h100, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1};
        vec[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h100, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1};
        vec[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h13,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h13, 1'b0};
        vec[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        vec[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hBAD,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        // Simultaneous: DM write first, then IF granted during the DM Valid cycle.
        vec[5]  = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h2000, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1};
        vec[6]  = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b1, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0};
        vec[7]  = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h104, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1};
        vec[8]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hC0FFEE,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hC0FFEE, 1'b0};
        vec[9]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        vec[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        // DM read: ack in IDLE ignored at grant, zero-wait ack, held through Valid, no re-grant.
        vec[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 32'h77,
                    1'b1, 1'b0, 32'h3000, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1};
        vec[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 32'h12345678,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678, 1'b0};
        vec[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        vec[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_mem_req", {31'b0, o_Mem_Req}, 32'h0);
        check("rst_busy", {31'b0, o_Busy}, 32'h0);
        check("rst_valids", {30'b0, o_IF_Valid, o_DM_Valid}, 32'h0);
        check("rst_addr", o_Mem_Addr, 32'h0);
        check("rst_be", {28'b0, o_Mem_ByteEnable}, 32'h0);
        check("rst_data", o_IF_Data, 32'h0);
        rst = 1'b0;
        cycle();

        // Vector table
        for (int i = 0; i < NV; i++) begin
            i_IF_Req        = vec[i].if_req;
            i_IF_Addr       = vec[i].if_addr;
            i_IF_Flush      = vec[i].if_flush;
            i_DM_Req        = vec[i].dm_req;
            i_DM_Write      = vec[i].dm_write;
            i_DM_Addr       = vec[i].dm_addr;
            i_DM_WriteData  = vec[i].dm_wdata;
            i_DM_ByteEnable = vec[i].dm_be;
            i_Mem_Ack       = vec[i].ack;
            i_Mem_ReadData  = vec[i].rdata;
            cycle();
            check($sformatf("v%0d_req", i), {31'b0, o_Mem_Req}, {31'b0, vec[i].e_req});
            check($sformatf("v%0d_busy", i), {31'b0, o_Busy}, {31'b0, vec[i].e_busy});
            check($sformatf("v%0d_ifv", i), {31'b0, o_IF_Valid}, {31'b0, vec[i].e_ifv});
            check($sformatf("v%0d_dmv", i), {31'b0, o_DM_Valid}, {31'b0, vec[i].e_dmv});
            if (vec[i].e_req) begin
                check($sformatf("v%0d_wr", i), {31'b0, o_Mem_Write}, {31'b0, vec[i].e_wr});
                check($sformatf("v%0d_addr", i), o_Mem_Addr, vec[i].e_addr);
                check($sformatf("v%0d_be", i), {28'b0, o_Mem_ByteEnable}, {28'b0, vec[i].e_be});
                if (vec[i].e_wr)
                    check($sformatf("v%0d_wdata", i), o_Mem_WriteData, vec[i].dm_wdata);
            end
            if (vec[i].e_ifv) check($sformatf("v%0d_ifdata", i), o_IF_Data, vec[i].e_resp);
            if (vec[i].e_dmv) check($sformatf("v%0d_dmdata", i), o_DM_ReadData, vec[i].e_resp);
        end
        i_Mem_Ack = 1'b0;

        // Starvation: DM held continuously, IF held; expect 4 DM grants then IF.
        auto_ack        = 1'b1;
        starve_mode     = 1'b1;
        i_DM_Req        = 1'b1;
        i_DM_Write      = 1'b0;
        i_DM_Addr       = 32'h5000;
        i_DM_ByteEnable = 4'hF;
        i_IF_Req        = 1'b1;
        i_IF_Addr       = 32'h600;
        dm_grants       = 0;
        cnt_at_if       = -1;
        if_seen         = 1'b0;
        prev_req        = 1'b0;
        for (int c = 0; c < 60 && !if_seen; c++) begin
            cycle();
            if (o_Mem_Req && !prev_req) begin
                if (o_Mem_Addr == 32'h600) begin
                    if_seen   = 1'b1;
                    cnt_at_if = int'(dut.cnt_q);
                end else begin
                    dm_grants++;
                end
            end
            prev_req = o_Mem_Req;
        end
        check("starve_if_grant", {31'b0, if_seen}, 32'h1);
        check("starve_dm_grants", dm_grants, 4);
        check("starve_cnt_clear", cnt_at_if, 0);
        got_v = 1'b0;
        for (int c = 0; c < 5 && !got_v; c++) begin
            cycle();
            if (o_IF_Valid) got_v = 1'b1;
        end
        check("starve_if_valid", {31'b0, got_v}, 32'h1);
        i_IF_Req    = 1'b0;
        i_DM_Req    = 1'b0;
        starve_mode = 1'b0;
        i_IF_Flush  = 1'b0;
        repeat (3) cycle();
        auto_ack  = 1'b0;
        i_Mem_Ack = 1'b0;
        cycle();

        // Flush one cycle before ack: bus completes, no IF Valid.
        i_IF_Req  = 1'b1;
        i_IF_Addr = 32'h40;
        cycle();
        check("flush_req", {31'b0, o_Mem_Req}, 32'h1);
        check("flush_addr", o_Mem_Addr, 32'h40);
        cycle();
        i_IF_Flush = 1'b1;
        cycle();
        check("flush_bus_held", {31'b0, o_Mem_Req}, 32'h1);
        i_IF_Flush     = 1'b0;
        i_IF_Req       = 1'b0;
        i_Mem_Ack      = 1'b1;
        i_Mem_ReadData = 32'h99;
        cycle();
        check("flush_bus_done", {31'b0, o_Mem_Req}, 32'h0);
        check("flush_no_valid", {31'b0, o_IF_Valid}, 32'h0);
        i_Mem_Ack = 1'b0;
        ifv_seen  = 1'b0;
        repeat (3) begin
            cycle();
            if (o_IF_Valid) ifv_seen = 1'b1;
        end
        check("flush_quiet", {31'b0, ifv_seen}, 32'h0);
        // Next fetch after flush is served normally.
        i_IF_Req  = 1'b1;
        i_IF_Addr = 32'h80;
        cycle();
        check("post_flush_addr", o_Mem_Addr, 32'h80);
        i_Mem_Ack      = 1'b1;
        i_Mem_ReadData = 32'h8080_8080;
        cycle();
        check("post_flush_valid", {31'b0, o_IF_Valid}, 32'h1);
        check("post_flush_data", o_IF_Data, 32'h8080_8080);
        i_IF_Req  = 1'b0;
        i_Mem_Ack = 1'b0;
        cycle();
        check("post_flush_pulse", {31'b0, o_IF_Valid}, 32'h0);

        // Flush in the ack cycle also suppresses Valid.
        i_IF_Req  = 1'b1;
        i_IF_Addr = 32'hC0;
        cycle();
        check("flush_ack_req", {31'b0, o_Mem_Req}, 32'h1);
        i_IF_Flush = 1'b1;
        i_IF_Req   = 1'b0;
        i_Mem_Ack  = 1'b1;
        cycle();
        check("flush_ack_no_valid", {31'b0, o_IF_Valid}, 32'h0);
        check("flush_ack_done", {31'b0, o_Busy}, 32'h0);
        i_IF_Flush = 1'b0;
        i_Mem_Ack  = 1'b0;
        cycle();

        // Reset mid-transaction during DM_BUSY, then a late ack in IDLE.
        i_DM_Req        = 1'b1;
        i_DM_Write      = 1'b1;
        i_DM_Addr       = 32'h4000;
        i_DM_WriteData  = 32'h1;
        i_DM_ByteEnable = 4'hC;
        cycle();
        check("mid_busy", {31'b0, o_Busy}, 32'h1);
        check("mid_be", {28'b0, o_Mem_ByteEnable}, 32'hC);
        #1;
        rst = 1'b1;
        #1;
        check("async_mem_req", {31'b0, o_Mem_Req}, 32'h0);
        check("async_busy", {31'b0, o_Busy}, 32'h0);
        check("async_valids", {30'b0, o_IF_Valid, o_DM_Valid}, 32'h0);
        check("async_addr", o_Mem_Addr, 32'h0);
        check("async_be", {28'b0, o_Mem_ByteEnable}, 32'h0);
        i_DM_Req = 1'b0;
        cycle();
        rst       = 1'b0;
        i_Mem_Ack = 1'b1;
        cycle();
        check("late_ack_req", {31'b0, o_Mem_Req}, 32'h0);
        check("late_ack_valids", {30'b0, o_IF_Valid, o_DM_Valid}, 32'h0);
        i_Mem_Ack = 1'b0;
        cycle();
        check("late_ack_after", {29'b0, o_IF_Valid, o_DM_Valid, o_Busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
